imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single read port of the instruction memory controller between two requesters: instruction fetch (IF) and data-side loads from instruction space (LD, e.g. constant/rodata reads).
- Drives the memory's address, stall and select_inst/select_data inputs, and routes the 1-cycle-latency read data back to the granted requester with a valid pulse.
- Sits between the fetch stage / load unit and the instruction memory controller.

Parameters:
- ADDR_W, 10, byte address width into instruction memory.
- DATA_W, 32, read data width.
- MAX_STARVE, 4, consecutive cycles IF may be denied while requesting before IF is force-granted; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  combinational grant to IF this cycle.
- if_valid  out  1  IF read data valid (cycle after if_gnt).
- if_rdata  out  DATA_W  IF read data.
- ld_req  in  1  load request; held with ld_addr stable until ld_gnt.
- ld_addr  in  ADDR_W  load byte address.
- ld_gnt  out  1  combinational grant to LD.
- ld_valid  out  1  LD read data valid (cycle after ld_gnt).
- ld_rdata  out  DATA_W  LD read data.
- mem_addr  out  ADDR_W  address to memory port.
- mem_stall  out  1  1 = memory holds its registered address.
- mem_sel_inst  out  1  select_inst to controller.
- mem_sel_data  out  1  select_data to controller.
- mem_rdata  in  DATA_W  read data from memory (valid 1 cycle after address accepted).

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, starve_cnt=0, owner=NONE. During reset cycles all grants, if_valid and ld_valid are 0. mem_stall=1, mem_sel_*=0, rdata outputs=0.
- Grant (combinational, at most one per cycle):
  - ld_req only -> LD.
  - if_req only -> IF.
  - Both -> LD, unless starve_cnt==MAX_STARVE, in which case IF.
- starve_cnt: +1 each cycle if_req=1 and if_gnt=0, saturating at MAX_STARVE; cleared on if_gnt or if_req=0.
- Granted cycle: mem_addr = granted addr; mem_stall=0; mem_sel_inst=if_gnt; mem_sel_data=ld_gnt. The controller registers the selects, so its mask aligns with the returned data.
- No grant: mem_stall=1, mem_sel_*=0, mem_addr=0.
- FSM: states IDLE, RESP_IF, RESP_LD; the state names the owner of data returning this cycle.
  - Next state = RESP_IF on if_gnt, RESP_LD on ld_gnt, else IDLE.
  - In RESP_IF: if_valid=1, if_rdata=mem_rdata. In RESP_LD: ld_valid=1, ld_rdata=mem_rdata.
  - Non-owner rdata=0.
- Latency: exactly 1 cycle from grant to valid. Back-to-back grants give full throughput of one read/cycle, including alternating IF/LD.
- A new grant may coincide with a valid for the previous grant (pipelined).
- Requester dropping req before grant: legal, no response. Changing addr while req is held and ungranted: unsupported; the address sampled is the one present in the grant cycle.
- Reset asserted with a response pending: the response is discarded; no valid is issued after reset.
- Address is passed unmodified (byte address); memory performs its own +0..+3 byte assembly.

Optional Feature:
- IMEM_ARB_RR_EN defined: fixed LD priority and starve_cnt are replaced by a 1-bit round-robin pointer.
  - On conflict, the requester not granted last is granted.
  - The pointer updates on every grant and resets to favour LD.
  - MAX_STARVE is ignored.
- Undefined: fixed-priority-with-starvation behaviour above.

Test Plan:
- IF alone, if_addr=0x010 held 3 cycles -> if_gnt every cycle; if_valid cycles 2..4 with mem words at 0x010; ld_valid=0 throughout.
- LD alone, ld_addr=0x100 one cycle -> ld_gnt=1, mem_sel_data=1 in same cycle; next cycle ld_valid=1, ld_rdata=word@0x100, then state IDLE, mem_stall=1.
- IF and LD both held continuously, MAX_STARVE=4 -> grant pattern LD,LD,LD,LD,IF repeating; every valid lands 1 cycle after its grant.
- Alternating grants IF@0x000, LD@0x200, IF@0x004 -> if_valid, ld_valid, if_valid on consecutive cycles with matching data; never both valid together.
- Reset asserted the cycle after an LD grant -> ld_valid stays 0; after reset release, outputs at reset values until the next request.
- With IMEM_ARB_RR_EN, both requesting continuously from reset -> grants LD,IF,LD,IF...

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares the instruction memory read port between fetch (IF) and load (LD) requesters.
// Define IMEM_ARB_RR_EN to replace fixed LD priority plus starvation guard with round-robin.
module imem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    output logic              o_ld_gnt,
    output logic              o_ld_valid,
    output logic [DATA_W-1:0] o_ld_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_stall,
    output logic              o_mem_sel_inst,
    output logic              o_mem_sel_data,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_LD = 2'd2
    } state_t;

    state_t r_state;
    logic   w_pick_if;
    logic   w_if_gnt;
    logic   w_ld_gnt;

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_starve
        $error("MAX_STARVE must lie in 1..15");
    end

`ifdef IMEM_ARB_RR_EN
    // Pointer names the requester that wins the next conflict; it favours LD out of reset.
    logic r_favour_ld;

    always_comb begin
        w_pick_if = i_if_req && (!i_ld_req || !r_favour_ld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_favour_ld <= 1'b1;
        end else if (w_if_gnt) begin
            r_favour_ld <= 1'b1;
        end else if (w_ld_gnt) begin
            r_favour_ld <= 1'b0;
        end
    end
`else
    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    logic [3:0] r_starve_cnt;

    always_comb begin
        w_pick_if = i_if_req && (!i_ld_req || (r_starve_cnt == STARVE_LIMIT));
    end

    // Counts consecutive denied IF cycles; saturates so IF keeps winning until it is served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (i_if_req && !w_if_gnt) begin
            if (r_starve_cnt != STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end
`endif

    assign w_if_gnt = !rst && w_pick_if;
    assign w_ld_gnt = !rst && i_ld_req && !w_pick_if;

    // State records who owns the data the memory returns in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (w_if_gnt) begin
            r_state <= RESP_IF;
        end else if (w_ld_gnt) begin
            r_state <= RESP_LD;
        end else begin
            r_state <= IDLE;
        end
    end

    assign o_if_gnt       = w_if_gnt;
    assign o_ld_gnt       = w_ld_gnt;
    assign o_mem_sel_inst = w_if_gnt;
    assign o_mem_sel_data = w_ld_gnt;
    assign o_mem_stall    = !(w_if_gnt || w_ld_gnt);
    assign o_mem_addr     = w_if_gnt ? i_if_addr : (w_ld_gnt ? i_ld_addr : '0);

    // Valids are gated by reset so a response pending at reset is dropped.
    assign o_if_valid = !rst && (r_state == RESP_IF);
    assign o_ld_valid = !rst && (r_state == RESP_LD);
    assign o_if_rdata = o_if_valid ? i_mem_rdata : '0;
    assign o_ld_rdata = o_ld_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: per-cycle vector table plus
// starvation/round-robin and reset-with-pending-response sequences.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef struct {
        logic              ifReq;
        logic [ADDR_W-1:0] ifAddr;
        logic              ldReq;
        logic [ADDR_W-1:0] ldAddr;
        logic              expIfGnt;
        logic              expLdGnt;
        logic              expIfValid;
        logic              expLdValid;
        logic [DATA_W-1:0] expIfRdata;
        logic [DATA_W-1:0] expLdRdata;
        logic [ADDR_W-1:0] expMemAddr;
        logic              expStall;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ifReq = 1'b0;
    logic [ADDR_W-1:0] ifAddr = '0;
    logic              ldReq = 1'b0;
    logic [ADDR_W-1:0] ldAddr = '0;
    logic              ifGnt, ifValid, ldGnt, ldValid;
    logic [DATA_W-1:0] ifRdata, ldRdata;
    logic [ADDR_W-1:0] memAddr;
    logic              memStall, memSelInst, memSelData;
    logic [DATA_W-1:0] memRdata = '0;

    int checks = 0;
    int failures = 0;

    vec_t vecs[15];

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_if_req       (ifReq),
        .i_if_addr      (ifAddr),
        .o_if_gnt       (ifGnt),
        .o_if_valid     (ifValid),
        .o_if_rdata     (ifRdata),
        .i_ld_req       (ldReq),
        .i_ld_addr      (ldAddr),
        .o_ld_gnt       (ldGnt),
        .o_ld_valid     (ldValid),
        .o_ld_rdata     (ldRdata),
        .o_mem_addr     (memAddr),
        .o_mem_stall    (memStall),
        .o_mem_sel_inst (memSelInst),
        .o_mem_sel_data (memSelData),
        .i_mem_rdata    (memRdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return {8'h5A, 6'd0, a, 8'hC3};
    endfunction

    // One-cycle-latency memory model: registers the accepted address and returns its word.
    always @(posedge clk) begin
        if (!memStall) memRdata <= memWord(memAddr);
    end

    function automatic vec_t mk(input logic ir, input logic [ADDR_W-1:0] ia,
                                input logic lr, input logic [ADDR_W-1:0] la,
                                input logic ig, input logic lg,
                                input logic iv, input logic [ADDR_W-1:0] iva,
                                input logic lv, input logic [ADDR_W-1:0] lva);
        vec_t v;
        v.ifReq      = ir;
        v.ifAddr     = ia;
        v.ldReq      = lr;
        v.ldAddr     = la;
        v.expIfGnt   = ig;
        v.expLdGnt   = lg;
        v.expIfValid = iv;
        v.expLdValid = lv;
        v.expIfRdata = iv ? memWord(iva) : '0;
        v.expLdRdata = lv ? memWord(lva) : '0;
        v.expMemAddr = ig ? ia : (lg ? la : '0);
        v.expStall   = !(ig || lg);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives inputs just after the falling edge; outputs are sampled 2ns later.
    task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                 input logic lr, input logic [ADDR_W-1:0] la);
        @(negedge clk);
        ifReq  = ir;
        ifAddr = ia;
        ldReq  = lr;
        ldAddr = la;
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, " ifGnt"},   32'(ifGnt),      32'(v.expIfGnt));
        checkOutput({tag, " ldGnt"},   32'(ldGnt),      32'(v.expLdGnt));
        checkOutput({tag, " selInst"}, 32'(memSelInst), 32'(v.expIfGnt));
        checkOutput({tag, " selData"}, 32'(memSelData), 32'(v.expLdGnt));
        checkOutput({tag, " stall"},   32'(memStall),   32'(v.expStall));
        checkOutput({tag, " memAddr"}, 32'(memAddr),    32'(v.expMemAddr));
        checkOutput({tag, " ifValid"}, 32'(ifValid),    32'(v.expIfValid));
        checkOutput({tag, " ldValid"}, 32'(ldValid),    32'(v.expLdValid));
        checkOutput({tag, " ifRdata"}, ifRdata,         v.expIfRdata);
        checkOutput({tag, " ldRdata"}, ldRdata,         v.expLdRdata);
    endtask

    // Main test sequence: reset state, vector table, arbitration pattern, reset with pending response.
    initial begin
        logic prevIf, prevLd, expIf;
        vec_t v;

        // IF alone held at 0x010 for three cycles
        vecs[0]  = mk(1, 10'h010, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h000);
        vecs[1]  = mk(1, 10'h010, 0, 10'h000, 1, 0, 1, 10'h010, 0, 10'h000);
        vecs[2]  = mk(1, 10'h010, 0, 10'h000, 1, 0, 1, 10'h010, 0, 10'h000);
        vecs[3]  = mk(0, 10'h000, 0, 10'h000, 0, 0, 1, 10'h010, 0, 10'h000);
        vecs[4]  = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);
        // LD alone at 0x100 for one cycle
        vecs[5]  = mk(0, 10'h000, 1, 10'h100, 0, 1, 0, 10'h000, 0, 10'h000);
        vecs[6]  = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h100);
        // Alternating IF@0x000, LD@0x200, IF@0x004
        vecs[7]  = mk(1, 10'h000, 0, 10'h000, 1, 0, 0, 10'h000, 0, 10'h000);
        vecs[8]  = mk(0, 10'h000, 1, 10'h200, 0, 1, 1, 10'h000, 0, 10'h000);
        vecs[9]  = mk(1, 10'h004, 0, 10'h000, 1, 0, 0, 10'h000, 1, 10'h200);
        vecs[10] = mk(0, 10'h000, 0, 10'h000, 0, 0, 1, 10'h004, 0, 10'h000);
        vecs[11] = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);
        // Conflict won by LD, then IF withdraws without ever being served
        vecs[12] = mk(1, 10'h040, 1, 10'h300, 0, 1, 0, 10'h000, 0, 10'h000);
        vecs[13] = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h300);
        vecs[14] = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);

        $display("[TB] reset checks");
        rst   = 1'b1;
        ifReq = 1'b1;
        ldReq = 1'b1;
        ldAddr = 10'h155;
        @(negedge clk);
        @(negedge clk);
        #2;
        v = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);
        checkVector(v, "reset");

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ifReq, vecs[i].ifAddr, vecs[i].ldReq, vecs[i].ldAddr);
            rst = 1'b0;
            #2;
            checkVector(vecs[i], $sformatf("v%0d", i));
        end

        $display("[TB] continuous conflict from reset");
        applyStimulus(0, 10'h000, 0, 10'h000);
        rst = 1'b1;
        prevIf = 1'b0;
        prevLd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 10'h020, 1, 10'h180);
            rst = 1'b0;
            #2;
`ifdef IMEM_ARB_RR_EN
            expIf = (c % 2) == 1;
`else
            expIf = (c % 5) == 4;
`endif
            v = mk(1, 10'h020, 1, 10'h180, expIf, !expIf, prevIf, 10'h020, prevLd, 10'h180);
            checkVector(v, $sformatf("arb%0d", c));
            prevIf = expIf;
            prevLd = !expIf;
        end
        applyStimulus(0, 10'h000, 0, 10'h000);
        #2;
        v = mk(0, 10'h000, 0, 10'h000, 0, 0, prevIf, 10'h020, prevLd, 10'h180);
        checkVector(v, "arbTail");

        $display("[TB] reset with pending LD response");
        applyStimulus(0, 10'h000, 1, 10'h0C0);
        #2;
        v = mk(0, 10'h000, 1, 10'h0C0, 0, 1, 0, 10'h000, 0, 10'h000);
        checkVector(v, "rstGnt");
        applyStimulus(1, 10'h044, 1, 10'h0C4);
        rst = 1'b1;
        #2;
        v = mk(0, 10'h000, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000);
        checkVector(v, "rstPend");
        applyStimulus(0, 10'h000, 0, 10'h000);
        rst = 1'b0;
        #2;
        checkVector(v, "rstRel0");
        applyStimulus(0, 10'h000, 0, 10'h000);
        #2;
        checkVector(v, "rstRel1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
